mem_arbiter: RTL and testbench

//  Shares one single-ported memory between the fetch stage (I-port, read-only) and the
//  MEM stage (D-port, read/write) of the MIPS pipeline. It runs a request/ack handshake
//  on each port and arbitrates fairly when both ports request together. A watchdog

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encodings, visible to trace/monitor code.
// Pure types, no logic.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between I-fetch (read-only) and D-port (read/write), fair tie-break.
// Latency: grant one edge after req is seen in IDLE, ack one edge after mem_ack; watchdog aborts stalled grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int TO_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ic_req,
    input  logic [WIDTH-1:0] ic_addr,
    output logic [WIDTH-1:0] ic_rdata,
    output logic             ic_ack,
    input  logic             dc_req,
    input  logic             dc_we,
    input  logic [WIDTH-1:0] dc_addr,
    input  logic [WIDTH-1:0] dc_wdata,
    output logic [WIDTH-1:0] dc_rdata,
    output logic             dc_ack,
    output logic             bus_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    arb_state_t          r_state;
    logic                r_last_d;
    logic                r_owner_d;
    logic [TO_WIDTH-1:0] r_wd;
    logic [TO_WIDTH-1:0] w_wd_next;
    logic                w_pick_d;

    assign w_wd_next = r_wd + {{(TO_WIDTH-1){1'b0}}, 1'b1};
    // D wins unless I is also waiting and D had the previous grant.
    assign w_pick_d  = dc_req && (!ic_req || !r_last_d);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ARB_IDLE;
            r_last_d  <= 1'b0;
            r_owner_d <= 1'b0;
            r_wd      <= '0;
            ic_rdata  <= '0;
            ic_ack    <= 1'b0;
            dc_rdata  <= '0;
            dc_ack    <= 1'b0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ic_ack  <= 1'b0;
            dc_ack  <= 1'b0;
            bus_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_d) begin
                        r_state   <= ARB_GNT_D;
                        r_last_d  <= 1'b1;
                        r_owner_d <= 1'b1;
                        r_wd      <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= dc_we;
                        mem_addr  <= dc_addr;
                        mem_wdata <= dc_wdata;
                    end else if (ic_req) begin
                        r_state   <= ARB_GNT_I;
                        r_last_d  <= 1'b0;
                        r_owner_d <= 1'b0;
                        r_wd      <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ic_addr;
                        mem_wdata <= '0;
                    end
                end
                ARB_GNT_I, ARB_GNT_D: begin
                    if (mem_ack) begin
                        r_state <= ARB_RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_owner_d) begin
                            dc_ack <= 1'b1;
                            // A write leaves the last read data visible.
                            if (!mem_we) dc_rdata <= mem_rdata;
                        end else begin
                            ic_ack   <= 1'b1;
                            ic_rdata <= mem_rdata;
                        end
                    end else if (w_wd_next == '1) begin
                        r_state <= ARB_RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                        if (r_owner_d) begin
                            dc_ack   <= 1'b1;
                            dc_rdata <= '0;
                        end else begin
                            ic_ack   <= 1'b1;
                            ic_rdata <= '0;
                        end
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end
                ARB_RESP: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, memory model with programmable ack delay.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] ic_rdata;
    logic        ic_ack;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic [31:0] dc_rdata;
    logic        dc_ack;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack;
    logic        model_ack = 1'b0;
    logic        stray_ack = 1'b0;

    bit mem_en = 1'b1;
    int mem_delay = 2;
    int mem_cnt = 0;
    int checks = 0;
    int errors = 0;
    bit prev_ack = 1'b0;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    assign mem_ack = model_ack | stray_ack;

    mem_arbiter #(.WIDTH(32), .TO_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2002000A : (32'h5A5A0000 | {16'h0, a[15:0]});
    endfunction

    // Memory model: acks mem_delay cycles after mem_req is first seen, one-cycle pulse.
    always @(negedge clk) begin
        if (model_ack) begin
            model_ack = 1'b0;
            mem_cnt = 0;
        end else if (mem_req && mem_en) begin
            mem_cnt++;
            if (mem_cnt >= mem_delay) begin
                model_ack = 1'b1;
                mem_rdata = mem_word(mem_addr);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        if (ic_ack || dc_ack) begin
            checks++;
            got = dc_ack ? dc_rdata : ic_rdata;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack ic_ack=%0b dc_ack=%0b rdata=%h required no ack", ic_ack, dc_ack, got);
            end else begin
                e = exp_q.pop_front();
                if ((ic_ack && dc_ack) || (dc_ack != e.is_d) || (got !== e.rdata) || (bus_err !== e.err) || prev_ack) begin
                    errors++;
                    $display("FAIL ack_scoreboard got d=%0b i=%0b rdata=%h err=%0b prev_ack=%0b required d=%0b rdata=%h err=%0b single-cycle",
                             dc_ack, ic_ack, got, bus_err, prev_ack, e.is_d, e.rdata, e.err);
                end
            end
        end
        prev_ack = ic_ack || dc_ack;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.is_d = is_d;
        e.rdata = rdata;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_memreq(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s mem_req never rose within 50 cycles", name);
        end
    endtask

    task automatic wait_acks(input int n, input string name);
        int got = 0;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(negedge clk);
            if (ic_ack || dc_ack) got++;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL %s acks seen=%0d required=%0d", name, got, n);
        end
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("reset_mem_req", mem_req, 0);
        check("reset_acks", {ic_ack, dc_ack, bus_err, mem_we}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rdata", ic_rdata | dc_rdata, 0);
        reset = 1'b1;

        // I-only fetch
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h40;
        push(1'b0, 32'h2002000A, 1'b0);
        wait_memreq("i_only");
        check("i_only_mem_we", mem_we, 0);
        check("i_only_mem_addr", mem_addr, 32'h40);
        wait_acks(1, "i_only");
        ic_req = 1'b0;

        // Tie after reset: D,I,D,I with both requests held
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h40;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h100;
        push(1'b1, 32'h5A5A0100, 1'b0);
        push(1'b0, 32'h2002000A, 1'b0);
        push(1'b1, 32'h5A5A0100, 1'b0);
        push(1'b0, 32'h2002000A, 1'b0);
        wait_acks(4, "tie");
        ic_req = 1'b0; dc_req = 1'b0;

        // D write: dc_rdata keeps the last read value
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h100; dc_wdata = 32'hDEADBEEF;
        push(1'b1, 32'h5A5A0100, 1'b0);
        wait_memreq("d_write");
        check("d_write_mem_we", mem_we, 1);
        check("d_write_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_acks(1, "d_write");
        dc_req = 1'b0; dc_we = 1'b0;

        // Watchdog timeout: 15 grant cycles, then error ack with zero data
        @(negedge clk);
        mem_en = 1'b0;
        dc_req = 1'b1; dc_addr = 32'h200;
        push(1'b1, 32'h0, 1'b1);
        wait_memreq("timeout");
        dc_req = 1'b0;
        cnt = 0;
        while (mem_req && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_grant_cycles", cnt, 15);
        check("timeout_ack_state", {dc_ack, bus_err, mem_req}, 3'b110);
        mem_en = 1'b1;

        // Reset in the middle of an I grant
        @(negedge clk);
        mem_delay = 4;
        ic_req = 1'b1; ic_addr = 32'h40;
        wait_memreq("reset_mid");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ic_req = 1'b0;
        check("reset_mid_mem_req", mem_req, 0);
        check("reset_mid_outputs", {ic_ack, dc_ack, bus_err, mem_we}, 0);
        check("reset_mid_ic_rdata", ic_rdata, 0);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_mid_late_ack", {mem_req, ic_ack}, 0);
        mem_delay = 2;

        // Stray mem_ack in IDLE
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_idle", {mem_req, ic_ack, dc_ack}, 0);

        // Stray mem_ack in RESP
        ic_req = 1'b1; ic_addr = 32'h40;
        push(1'b0, 32'h2002000A, 1'b0);
        wait_acks(1, "stray_resp_txn");
        ic_req = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_resp_next", {mem_req, ic_ack, dc_ack}, 0);
        @(negedge clk);
        check("stray_resp_no_regrant", mem_req, 0);

        // Normal D read afterwards
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h100;
        push(1'b1, 32'h5A5A0100, 1'b0);
        wait_acks(1, "post_stray_read");
        dc_req = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
